// File: rtl/instruction_fetch_if.sv
// Instruction-fetch bundle: hazard/branch controls, instruction-memory port and IF/ID outputs.
// The master side is the fetch stage; the slave side is memory plus downstream pipeline.
interface instruction_fetch_if;
    logic        start;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] pc_out;
    logic [31:0] instr_in;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc_plus4;
    logic        ifid_valid;
    logic        done;
    logic [15:0] fetch_count;

    modport master (
        input  start, stall, branch_taken, branch_target, instr_in,
        output pc_out, ifid_instr, ifid_pc_plus4, ifid_valid, done, fetch_count
    );

    modport slave (
        output start, stall, branch_taken, branch_target, instr_in,
        input  pc_out, ifid_instr, ifid_pc_plus4, ifid_valid, done, fetch_count
    );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: program counter, zero-wait instruction-memory addressing and IF/ID register,
// with start-up gating, stall hold, branch redirect/flush and end-of-program halt.
module instruction_fetch #(
    parameter int unsigned MEM_BYTES = 60,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                reset,
    instruction_fetch_if.master bus
);
    localparam logic [1:0]  S_IDLE  = 2'd0;
    localparam logic [1:0]  S_FETCH = 2'd1;
    localparam logic [1:0]  S_HALT  = 2'd2;
    localparam logic [31:0] LAST_PC = 32'(MEM_BYTES - 4);

    logic [1:0]  state, state_next;
    logic [31:0] pc, pc_next;
    logic [31:0] ifid_instr, instr_next;
    logic [31:0] ifid_pc_plus4, pc_plus4_next;
    logic        ifid_valid, valid_next;
    logic [15:0] fetch_count, count_next;
    logic        done;

    logic [31:0] target_pc;
    logic [31:0] pc_plus4;

    assign target_pc = {bus.branch_target[31:2], 2'b00};
    assign pc_plus4  = pc + 32'd4;

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_next    = state;
        pc_next       = pc;
        instr_next    = ifid_instr;
        pc_plus4_next = ifid_pc_plus4;
        valid_next    = ifid_valid;
        count_next    = fetch_count;

        case (state)
            S_IDLE: begin
                pc_next       = RESET_PC;
                instr_next    = 32'h0;
                pc_plus4_next = 32'h0;
                valid_next    = 1'b0;
                if (bus.start) state_next = S_FETCH;
            end
            S_FETCH: begin
                if (bus.branch_taken) begin
                    pc_next       = target_pc;
                    instr_next    = 32'h0;
                    pc_plus4_next = 32'h0;
                    valid_next    = 1'b0;
                    if (target_pc > LAST_PC) state_next = S_HALT;
                end else if (!bus.stall) begin
                    pc_next       = pc_plus4;
                    instr_next    = bus.instr_in;
                    pc_plus4_next = pc_plus4;
                    valid_next    = 1'b1;
                    if (fetch_count != 16'hFFFF) count_next = fetch_count + 16'd1;
                    if (pc_plus4 > LAST_PC) state_next = S_HALT;
                end
            end
            S_HALT: begin
                // PC keeps the last fetch address unless a redirect lands back in range.
                if (bus.branch_taken) begin
                    instr_next    = 32'h0;
                    pc_plus4_next = 32'h0;
                    valid_next    = 1'b0;
                    if (target_pc <= LAST_PC) begin
                        pc_next    = target_pc;
                        state_next = S_FETCH;
                    end
                end else if (!bus.stall) begin
                    instr_next    = 32'h0;
                    pc_plus4_next = 32'h0;
                    valid_next    = 1'b0;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            pc            <= RESET_PC;
            ifid_instr    <= 32'h0;
            ifid_pc_plus4 <= 32'h0;
            ifid_valid    <= 1'b0;
            fetch_count   <= 16'h0;
            done          <= 1'b0;
        end else begin
            state         <= state_next;
            pc            <= pc_next;
            ifid_instr    <= instr_next;
            ifid_pc_plus4 <= pc_plus4_next;
            ifid_valid    <= valid_next;
            fetch_count   <= count_next;
            done          <= (state_next == S_HALT);
        end
    end

    assign bus.pc_out        = pc;
    assign bus.ifid_instr    = ifid_instr;
    assign bus.ifid_pc_plus4 = ifid_pc_plus4;
    assign bus.ifid_valid    = ifid_valid;
    assign bus.done          = done;
    assign bus.fetch_count   = fetch_count;
endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage of the pipelined CPU and the initiator side of the instruction-memory interface. Holds the program counter, drives the byte address into the combinational instruction memory, and captures the returned big-endian word into the IF/ID pipeline register. Handles start-up, load-use stalls, taken-branch redirects with flush, and end-of-program detection.

## Interface
- MEM_BYTES, 60: instruction-memory size in bytes; valid fetch addresses are 0 .. MEM_BYTES-4.
- RESET_PC, 0: PC value after reset and the first fetch address.

- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  level; while low in IDLE, no fetch occurs (memory still loading)
- stall  input  1  hazard-unit hold: freeze PC and IF/ID
- branch_taken  input  1  resolved taken branch, valid this cycle
- branch_target  input  32  byte address of the branch target
- pc_out  output  32  fetch address to instruction memory (combinational from PC)
- instr_in  input  32  word returned by memory for pc_out in the same cycle
- ifid_instr  output  32  registered instruction
- ifid_pc_plus4  output  32  registered PC+4 of that instruction
- ifid_valid  output  1  IF/ID holds a real instruction (0 = bubble)
- done  output  1  program ran off the end; no further fetches
- fetch_count  output  16  number of instructions latched with ifid_valid=1, saturating

## Operation
- States: IDLE, FETCH, HALT.
- IDLE: PC = RESET_PC, IF/ID bubble. start=1 -> FETCH on the next edge; the first fetch address is RESET_PC.
- FETCH, per edge, priority reset > branch_taken > stall > normal:
  - branch_taken: PC <= {branch_target[31:2], 2'b00}; IF/ID flushed (instr 0, valid 0). Overrides stall.
  - stall: PC, IF/ID, and fetch_count hold.
  - normal: IF/ID <= {instr_in, PC+4, valid 1}; PC <= PC+4; fetch_count += 1, saturating at 16'hFFFF.
  - PC (after redirect or increment) > MEM_BYTES-4 -> HALT. The word at the last valid address is still latched normally.
- HALT: done=1; pc_out holds the last PC; IF/ID loads bubbles each unstalled cycle. branch_taken with an in-range aligned target -> FETCH at that target, done drops the next cycle. An out-of-range target stays in HALT.
- Misaligned targets have their low 2 bits forced to 0. No exception is raised.
- Arithmetic is 32-bit unsigned with wrap. The range check uses the unsigned compare PC > MEM_BYTES-4.
- start is ignored outside IDLE. Dropping start mid-run does not stop fetch.

## Timing
- Reset values, on the edge where reset=1: state IDLE, PC=RESET_PC, ifid_instr=0, ifid_pc_plus4=0, ifid_valid=0, done=0, fetch_count=0. Reset mid-run aborts immediately and discards any pending redirect.
- pc_out is the PC register, so it changes only on clock edges. instr_in is sampled at the edge that ends the cycle in which pc_out was presented (zero-wait memory).
- Fetch latency: an instruction at address A appears on ifid_instr one edge after pc_out=A. From start rising in IDLE, the first valid IF/ID is 2 edges later.
- Redirect: branch_taken sampled at edge N. At N, pc_out becomes the target and IF/ID becomes a bubble. The target instruction is valid in IF/ID after N+1. Exactly one bubble is inserted by this block; earlier wrong-path squashing belongs to downstream stages.
- stall and branch_taken in the same cycle: redirect wins, with no hold.
- done is registered and asserts on the edge that enters HALT.

## Test plan
- Reset/start: hold reset 2 cycles, then start=1. Required: all outputs 0 during reset. pc_out = 0, 4, 8, ... on successive edges. First ifid_valid=1 with ifid_pc_plus4=4 two edges after start. fetch_count increments by 1 per edge.
- Stall: at pc_out=32, assert stall for 3 cycles. Required: pc_out stays 32, IF/ID holds the word from 28, fetch_count is frozen. Resume fetches 32 next.
- Branch: at pc_out=28, branch_taken=1 with branch_target=56. Required: next pc_out=56 and ifid_valid=0. Next edge: IF/ID holds the word at 56 with ifid_pc_plus4=60.
- Branch + stall simultaneous: stall=1, branch_taken=1, target=26. Required: pc_out=24 (aligned), IF/ID flushed, stall ignored.
- End of program: free-run from 0 with no branches. Required: the word at 56 is latched valid, then state HALT, done=1, and ifid_valid=0 thereafter. fetch_count=15.
- Restart from HALT: in HALT, branch_taken with target=24. Required: done=0 next cycle, pc_out=24, fetch resumes. With target=100 instead, the block stays in HALT with done=1.
